key_schedule_loop: RTL

RC4 key-scheduling (second-loop) FSM; the stage directly upstream of the decrypt loop.
Takes an S-RAM already initialised to s[i]=i and performs the 256-iteration keyed shuffle: j = j + s[i] + key[i mod 3], then swap s[i] and s[j].
Uses the same START/FINISH handshake and shared S-RAM port style as the neighbouring loops.
A top-level controller starts it after the init loop and starts the decrypt loop on its finish pulse.

---
 rtl/key_schedule_loop.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_schedule_loop.sv
// key_schedule_loop
//   RC4 key-scheduling second loop. It expects an S-RAM that already holds
//   s[i] = i and performs the keyed shuffle for i = 0..255:
//     j = j + s[i] + key[i mod KEY_BYTES];  swap(s[i], s[j])
//   A single shared S-RAM port is used for all reads and writes. Reads take
//   RD_WAIT wait states between presenting an address and sampling s_ram_q.
//
// Optional build macro:
//   SKIP_SELF_SWAP_EN - when defined, an iteration with j == i skips both
//                       writes and goes straight to CHECK (10 cycles instead
//                       of 14 at RD_WAIT = 2).
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous active-high reset
//   start      - begin a shuffle; sampled only in IDLE
//   secret_key - key bytes, byte0 in the top byte; hold stable while busy
//   s_ram_q    - S-RAM read data
//   s_address  - S-RAM address
//   s_data     - S-RAM write data
//   s_wren     - S-RAM write enable (high only in WR_I / WR_J)
//   finish     - one-cycle done pulse (FINISH state)
module key_schedule_loop #(
  parameter int KEY_BYTES = 3,
  parameter int RD_WAIT   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  input  logic [7:0]             s_ram_q,
  output logic [7:0]             s_address,
  output logic [7:0]             s_data,
  output logic                   s_wren,
  output logic                   finish
);

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam int WW = (RD_WAIT > 1) ? $clog2(RD_WAIT) : 1;
  localparam logic [KW-1:0] KIDX_LAST = KW'(KEY_BYTES - 1);
  localparam logic [WW-1:0] WAIT_LAST = WW'(RD_WAIT - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_REQ_I, S_WAIT_I, S_READ_I, S_COMP_J, S_REQ_J, S_WAIT_J,
    S_READ_J, S_PRE_WR_I, S_WR_I, S_PRE_WR_J, S_WR_J, S_CHECK, S_FINISH
  } state_t;

  state_t          state, next;
  logic [7:0]      i, j, si, sj;
  logic [KW-1:0]   kidx;
  logic [WW-1:0]   wait_cnt;
  logic [7:0]      key_byte;

  // Key byte select: kidx is a wrap-around counter, so a plain mux suffices.
  always_comb begin
    key_byte = '0;
    for (int k = 0; k < KEY_BYTES; k++)
      if (kidx == KW'(k)) key_byte = secret_key[8*(KEY_BYTES-1-k) +: 8];
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= next;
  end

  // Next-state logic
  always_comb begin
    next = state;
    case (state)
      S_IDLE:     if (start) next = S_REQ_I;
      S_REQ_I:    next = (RD_WAIT > 0) ? S_WAIT_I : S_READ_I;
      S_WAIT_I:   if (wait_cnt == WAIT_LAST) next = S_READ_I;
      S_READ_I:   next = S_COMP_J;
      S_COMP_J:   next = S_REQ_J;
      S_REQ_J:    next = (RD_WAIT > 0) ? S_WAIT_J : S_READ_J;
      S_WAIT_J:   if (wait_cnt == WAIT_LAST) next = S_READ_J;
`ifdef SKIP_SELF_SWAP_EN
      S_READ_J:   next = (j == i) ? S_CHECK : S_PRE_WR_I;
`else
      S_READ_J:   next = S_PRE_WR_I;
`endif
      S_PRE_WR_I: next = S_WR_I;
      S_WR_I:     next = S_PRE_WR_J;
      S_PRE_WR_J: next = S_WR_J;
      S_WR_J:     next = S_CHECK;
      S_CHECK:    next = (i == 8'hFF) ? S_FINISH : S_REQ_I;
      S_FINISH:   next = S_IDLE;
      default:    next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    s_wren = (state == S_WR_I) || (state == S_WR_J);
    finish = (state == S_FINISH);
  end

  // Wait-state counter, cleared outside the wait states
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      wait_cnt <= '0;
    else if ((state == S_WAIT_I || state == S_WAIT_J) && wait_cnt != WAIT_LAST)
      wait_cnt <= wait_cnt + 1'b1;
    else
      wait_cnt <= '0;
  end

  // Datapath. Write address/data are loaded on the edge that enters each
  // PRE_WR state so they are stable across both PRE_WR and WR; the write
  // data for s[i] is taken straight from s_ram_q in the same edge that
  // captures sj.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      i         <= '0;
      j         <= '0;
      kidx      <= '0;
      si        <= '0;
      sj        <= '0;
      s_address <= '0;
      s_data    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          i    <= '0;
          j    <= '0;
          kidx <= '0;
        end
        S_REQ_I:  s_address <= i;
        S_READ_I: si <= s_ram_q;
        S_COMP_J: j <= j + si + key_byte;
        S_REQ_J:  s_address <= j;
        S_READ_J: begin
          sj        <= s_ram_q;
          s_address <= i;
          s_data    <= s_ram_q;
        end
        S_WR_I: begin
          s_address <= j;
          s_data    <= si;
        end
        S_CHECK: begin
          // i stops at 255; FINISH follows, so i never wraps within a run
          if (i != 8'hFF) begin
            i    <= i + 1'b1;
            kidx <= (kidx == KIDX_LAST) ? '0 : kidx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
